avalon_ram_model: RTL and testbench
===================================

Name: avalon_ram_model

Overview:
- Parametrised successor to the simple testbench RAM used by the CPU benches.
- Provides an Avalon-MM slave (`address`, `read`, `write`, `waitrequest`, `writedata`, `byteenable`, `readdata`) with configurable depth, base address and wait-state count.
- Provides a bench-side program-load port so benches can preload instructions.
- Sits beside `top_level_cpu` in every CPU testbench; exercises the CPU's waitrequest stall handling.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two.
- BASE_ADDR, 32'hBFC00000: byte address mapped to word 0.
- WAIT_CYCLES, 2: extra stall cycles per access beyond the minimum; range 0..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  32  byte address from CPU.
- read  in  1  read request.
- write  in  1  write request.
- writedata  in  32  write data.
- byteenable  in  4  byte lane enables; bit i covers writedata[8i+7:8i].
- waitrequest  out  1  stall: master holds request while high.
- readdata  out  32  read data; valid in the cycle read is high and waitrequest is low.
- load_en  in  1  program-load strobe.
- load_addr  in  32  byte address for load, same mapping as `address`.
- load_data  in  32  word written by load.
- bus_err  out  1  one-cycle pulse on an out-of-range or read+write access.

Behaviour:
- Address mapping:
  - word index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored.
  - In range iff 0 <= index < DEPTH_WORDS, using unsigned 32-bit subtraction.
- FSM states: IDLE, BUSY, ACK.
- IDLE:
  - On read|write: latch address, writedata, byteenable and direction.
  - If WAIT_CYCLES=0 go to ACK; otherwise go to BUSY with cnt=WAIT_CYCLES-1.
- BUSY: decrement cnt; go to ACK when cnt=0.
- ACK: unconditionally return to IDLE.
- `waitrequest` = (read|write) & (state != ACK), combinational.
  - So every access spends WAIT_CYCLES+2 cycles with the request asserted; waitrequest is low only in the last of them.
- Read: `readdata` registered on the transition into ACK from the latched index. It holds until the next ACK entry.
- Write:
  - Committed on the transition into ACK.
  - Only enabled byte lanes are updated; byteenable=0 is a legal no-op.
- Out of range:
  - Read returns 32'h0 and write is dropped.
  - `bus_err` pulses in the ACK cycle.
  - Handshake still completes normally.
- read and write both high in IDLE: treated as write, readdata forced to 0, `bus_err` pulses in ACK.
- Request dropped by the master while in BUSY: FSM still runs to ACK and back to IDLE, and the write still commits. This is a protocol violation, not detected.
- Load port:
  - When load_en=1, mem[index(load_addr)] <= load_data on the clock edge, in any FSM state; out-of-range loads are ignored.
  - A load and a bus write to the same word on the same edge: the load wins.
- Reset (async, active-low):
  - FSM goes to IDLE, cnt=0, readdata=0, bus_err=0.
  - waitrequest follows its equation, so it is high if a request is present.
  - Memory contents are NOT cleared, so benches may load before or during reset.
- Reset mid-transaction: access aborted, write not committed; the master re-issues after reset release.

Optional Feature:
- Macro: RAM_RANDOM_WAIT_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per accepted access.
  - The per-access stall count is lfsr[3:0] mod (WAIT_CYCLES+1), replacing the fixed WAIT_CYCLES.
  - All other rules are unchanged.
- Undefined: fixed WAIT_CYCLES stalls; no LFSR logic present.

Test Plan:
1. Load and read back: load_en writes 32'h24020010 at load_addr BFC00000, reset released; read BFC00000 with WAIT_CYCLES=2 -> waitrequest high 3 cycles, low on 4th with readdata=32'h24020010, bus_err=0.
2. Byte-lane write: word BFC00010=32'h11223344; write writedata=32'hAABBCCDD, byteenable=4'b0101 -> subsequent read returns 32'h11BB33DD.
3. Out-of-range access: read BFC00000+4*DEPTH_WORDS -> handshake completes after WAIT_CYCLES+2 cycles, readdata=0, bus_err one-cycle pulse; write at same address leaves memory unchanged.
4. Reset mid-access: write to BFC00020 (old value 32'h0), reset asserted while in BUSY -> readdata=0, FSM in IDLE, word still 32'h0; write re-issued after release succeeds.
5. Load/bus collision: load 32'hCAFEF00D and bus write 32'h12345678 to BFC00030 committing on the same edge -> read returns 32'hCAFEF00D.
6. Both read and write high to BFC00040 with WAIT_CYCLES=0 -> waitrequest high 1 cycle, then ACK with readdata=0 and bus_err pulse; memory word equals writedata. With RAM_RANDOM_WAIT_EN, 100 reads: every stall length lies in 0..WAIT_CYCLES and data matches preload.

Source files
------------

// File: rtl/avalon_ram_model.sv
// avalon_ram_model: Avalon-MM slave RAM for CPU benches.
// Fixed stall of WAIT_CYCLES per access. Define RAM_RANDOM_WAIT_EN for a
// per-access LFSR-driven stall in 0..WAIT_CYCLES. A bench-side load port
// preloads words in any FSM state. Memory contents survive reset.
module avalon_ram_model #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        bus_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] lat_idx;
  logic             lat_in_range;
  logic             lat_wr;
  logic             lat_both;
  logic [31:0]      lat_wdata;
  logic [3:0]       lat_be;

  logic [31:0]      mem [DEPTH_WORDS];

  // Unsigned subtraction: addresses below BASE_ADDR wrap high and fall out of range.
  function automatic logic in_range_f(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return {2'b00, off[31:2]} < 32'(DEPTH_WORDS);
  endfunction

  function automatic logic [IDX_W-1:0] idx_f(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off[IDX_W+1:2];
  endfunction

  logic             req;
  logic             accept;
  logic [3:0]       stall_sel;
  logic             ack_entry;
  logic             commit_wr;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_in_range;
  logic             cur_wr;
  logic             cur_both;
  logic [31:0]      cur_wdata;
  logic [3:0]       cur_be;

  assign req         = read | write;
  assign accept      = (state == IDLE) && req;
  assign waitrequest = req && (state != ACK);

`ifdef RAM_RANDOM_WAIT_EN
  logic [15:0] lfsr;
  logic [4:0]  stall_mod;
  assign stall_mod = {1'b0, lfsr[3:0]} % 5'(WAIT_CYCLES + 1);
  assign stall_sel = stall_mod[3:0];

  // Galois LFSR (taps 16,14,13,11) stepped once per accepted access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      lfsr <= 16'hACE1;
    else if (accept) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end
`else
  assign stall_sel = 4'(WAIT_CYCLES);
`endif

  // A zero-stall access enters ACK straight from IDLE, before anything is
  // latched, so the commit path must see the live bus in that case.
  always_comb begin
    if (state == IDLE) begin
      cur_idx      = idx_f(address);
      cur_in_range = in_range_f(address);
      cur_wr       = write;
      cur_both     = read & write;
      cur_wdata    = writedata;
      cur_be       = byteenable;
    end else begin
      cur_idx      = lat_idx;
      cur_in_range = lat_in_range;
      cur_wr       = lat_wr;
      cur_both     = lat_both;
      cur_wdata    = lat_wdata;
      cur_be       = lat_be;
    end
  end

  assign ack_entry = (accept && stall_sel == 4'd0) || (state == BUSY && cnt == 4'd0);
  // Held-low reset keeps the FSM in IDLE; gate so no write slips through.
  assign commit_wr = ack_entry && reset && cur_wr && cur_in_range;

  // Handshake FSM with registered readdata and bus_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      readdata     <= 32'h0;
      bus_err      <= 1'b0;
      lat_idx      <= '0;
      lat_in_range <= 1'b0;
      lat_wr       <= 1'b0;
      lat_both     <= 1'b0;
      lat_wdata    <= 32'h0;
      lat_be       <= 4'h0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: if (req) begin
          lat_idx      <= cur_idx;
          lat_in_range <= cur_in_range;
          lat_wr       <= cur_wr;
          lat_both     <= cur_both;
          lat_wdata    <= cur_wdata;
          lat_be       <= cur_be;
          if (stall_sel == 4'd0) state <= ACK;
          else begin
            state <= BUSY;
            cnt   <= stall_sel - 4'd1;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) state <= ACK;
          else             cnt   <= cnt - 4'd1;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
      if (ack_entry) begin
        bus_err <= !cur_in_range || cur_both;
        if (cur_both)     readdata <= 32'h0;
        else if (!cur_wr) readdata <= cur_in_range ? mem[cur_idx] : 32'h0;
      end
    end
  end

  // Storage: byte-lane bus writes, then loads; the later NBA lets a load win.
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      for (int b = 0; b < 4; b++)
        if (cur_be[b]) mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
    end
    if (load_en && in_range_f(load_addr))
      mem[idx_f(load_addr)] <= load_data;
  end

endmodule

// File: tb/tb_avalon_ram_model.sv
// Directed bench for avalon_ram_model: table of load/read/write vectors on a
// WAIT_CYCLES=2 instance plus hand sequences for reset, load collision and a
// WAIT_CYCLES=0 instance with read+write both high.
module tb_avalon_ram_model;

  localparam int          DEPTH = 64;
  localparam int          W     = 2;
  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam logic [1:0]  OP_LD = 2'd0, OP_WR = 2'd1, OP_RD = 2'd2;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_s [2];
  logic        wr_s [2];
  logic [31:0] addr_s [2];
  logic [31:0] wd_s [2];
  logic [3:0]  be_s [2];
  logic        wreq [2];
  logic [31:0] rdat [2];
  logic        err [2];
  logic        load_en;
  logic [31:0] load_addr, load_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  avalon_ram_model #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset), .address(addr_s[0]), .read(rd_s[0]), .write(wr_s[0]),
    .writedata(wd_s[0]), .byteenable(be_s[0]), .waitrequest(wreq[0]), .readdata(rdat[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .bus_err(err[0]));

  avalon_ram_model #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .address(addr_s[1]), .read(rd_s[1]), .write(wr_s[1]),
    .writedata(wd_s[1]), .byteenable(be_s[1]), .waitrequest(wreq[1]), .readdata(rdat[1]),
    .load_en(1'b0), .load_addr(32'h0), .load_data(32'h0), .bus_err(err[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Number of waitrequest-high cycles an access may take on an instance with wait w.
  function automatic logic wait_ok(input int n, input int w);
`ifdef RAM_RANDOM_WAIT_EN
    return (n >= 1) && (n <= w + 1);
`else
    return n == w + 1;
`endif
  endfunction

  // Entered at posedge+1 with the DUT idle; returns at posedge+1 idle again.
  task automatic access(input int u, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output logic [31:0] rdata, output logic e, output logic e_after,
                        output int nwait);
    rd_s[u] = rd; wr_s[u] = wr; addr_s[u] = a; wd_s[u] = d; be_s[u] = be;
    nwait = 0;
    #1;
    for (int k = 0; k < 40 && wreq[u]; k++) begin
      nwait++;
      @(posedge clk); #2;
    end
    if (wreq[u]) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: waitrequest still %b at %h, expected 0", wreq[u], a);
    end
    rdata = rdat[u];
    e     = err[u];
    rd_s[u] = 1'b0; wr_s[u] = 1'b0;
    @(posedge clk); #1;
    e_after = err[u];
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  initial begin
    vec_t        vecs [$];
    logic [31:0] rv;
    logic        ev, eav;
    int          nw;

    vecs.push_back('{OP_LD, BASE + 32'h10, 32'h11223344, 4'h0, 32'h0,          1'b0});
    vecs.push_back('{OP_WR, BASE + 32'h10, 32'hAABBCCDD, 4'h5, 32'h0,          1'b0});
    vecs.push_back('{OP_RD, BASE + 32'h10, 32'h0,        4'h0, 32'h11BB33DD,   1'b0});
    vecs.push_back('{OP_RD, BASE + 32'h13, 32'h0,        4'h0, 32'h11BB33DD,   1'b0});
    vecs.push_back('{OP_LD, BASE + 32'h08, 32'h01020304, 4'h0, 32'h0,          1'b0});
    vecs.push_back('{OP_WR, BASE + 32'h08, 32'hFFFFFFFF, 4'h0, 32'h0,          1'b0});
    vecs.push_back('{OP_RD, BASE + 32'h08, 32'h0,        4'h0, 32'h01020304,   1'b0});
    vecs.push_back('{OP_LD, BASE + 32'h14, 32'h00000000, 4'h0, 32'h0,          1'b0});
    vecs.push_back('{OP_WR, BASE + 32'h14, 32'h87654321, 4'hA, 32'h0,          1'b0});
    vecs.push_back('{OP_RD, BASE + 32'h14, 32'h0,        4'h0, 32'h87004300,   1'b0});
    vecs.push_back('{OP_LD, BASE + 32'hFC, 32'h5A5A5A5A, 4'h0, 32'h0,          1'b0});
    vecs.push_back('{OP_RD, BASE + 32'hFC, 32'h0,        4'h0, 32'h5A5A5A5A,   1'b0});
    vecs.push_back('{OP_RD, BASE + 32'h100, 32'h0,       4'h0, 32'h0,          1'b1});
    vecs.push_back('{OP_WR, BASE + 32'h100, 32'hDEADBEEF, 4'hF, 32'h0,         1'b1});
    vecs.push_back('{OP_RD, BASE,          32'h0,        4'h0, 32'h24020010,   1'b0});
    vecs.push_back('{OP_RD, 32'hBFBFFFFC,  32'h0,        4'h0, 32'h0,          1'b1});
    vecs.push_back('{OP_RD, 32'h00000000,  32'h0,        4'h0, 32'h0,          1'b1});

    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    for (int u = 0; u < 2; u++) begin
      rd_s[u] = 1'b0; wr_s[u] = 1'b0; addr_s[u] = '0; wd_s[u] = '0; be_s[u] = '0;
    end

    // Preload while reset is held, then check reset outputs.
    #2;
    load(BASE, 32'h24020010);
    check("rst_waitrequest", {31'b0, wreq[0]}, 32'h0);
    check("rst_readdata",    rdat[0],          32'h0);
    check("rst_bus_err",     {31'b0, err[0]},  32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Load then read back.
    access(0, 1'b1, 1'b0, BASE, 32'h0, 4'h0, rv, ev, eav, nw);
    check("load_read_data",  rv,                          32'h24020010);
    check("load_read_waits", {31'b0, wait_ok(nw, W)},     32'h1);
    check("load_read_err",   {31'b0, ev},                 32'h0);

    // Table of loads, byte-lane writes and in/out-of-range reads.
    foreach (vecs[i]) begin
      if (vecs[i].op == OP_LD) begin
        load(vecs[i].addr, vecs[i].data);
      end else begin
        access(0, vecs[i].op == OP_RD, vecs[i].op == OP_WR, vecs[i].addr, vecs[i].data,
               vecs[i].be, rv, ev, eav, nw);
        if (vecs[i].op == OP_RD) check($sformatf("vec%0d_data", i), rv, vecs[i].exp);
        check($sformatf("vec%0d_err", i),   {31'b0, ev},             {31'b0, vecs[i].exp_err});
        check($sformatf("vec%0d_pulse", i), {31'b0, eav},            32'h0);
        check($sformatf("vec%0d_waits", i), {31'b0, wait_ok(nw, W)}, 32'h1);
      end
    end

    // Reset during BUSY aborts the write; re-issued write then lands.
    load(BASE + 32'h20, 32'h0);
    access(0, 1'b1, 1'b0, BASE, 32'h0, 4'h0, rv, ev, eav, nw);
    wr_s[0] = 1'b1; addr_s[0] = BASE + 32'h20; wd_s[0] = 32'hFFFFFFFF; be_s[0] = 4'hF;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("midrst_readdata",    rdat[0],          32'h0);
    check("midrst_bus_err",     {31'b0, err[0]},  32'h0);
    check("midrst_waitrequest", {31'b0, wreq[0]}, 32'h1);
    wr_s[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'h0, rv, ev, eav, nw);
    check("midrst_word_kept", rv, 32'h0);
    access(0, 1'b0, 1'b1, BASE + 32'h20, 32'hAABB0011, 4'hF, rv, ev, eav, nw);
    access(0, 1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'h0, rv, ev, eav, nw);
    check("midrst_reissue", rv, 32'hAABB0011);

    // Load held across the bus write's commit edge, dropped in ACK.
    load_en = 1'b1; load_addr = BASE + 32'h30; load_data = 32'hCAFEF00D;
    wr_s[0] = 1'b1; addr_s[0] = BASE + 32'h30; wd_s[0] = 32'h12345678; be_s[0] = 4'hF;
    #1;
    for (int k = 0; k < 40 && wreq[0]; k++) begin
      @(posedge clk); #2;
    end
    check("collide_ack", {31'b0, wreq[0]}, 32'h0);
    load_en = 1'b0; wr_s[0] = 1'b0;
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, BASE + 32'h30, 32'h0, 4'h0, rv, ev, eav, nw);
    check("collide_load_wins", rv, 32'hCAFEF00D);

    // Zero-wait instance: plain write/read, then read+write both high.
    access(1, 1'b0, 1'b1, BASE + 32'h44, 32'h600DF00D, 4'hF, rv, ev, eav, nw);
    check("w0_write_waits", nw, 32'd1);
    access(1, 1'b1, 1'b0, BASE + 32'h44, 32'h0, 4'h0, rv, ev, eav, nw);
    check("w0_read_data",  rv, 32'h600DF00D);
    check("w0_read_waits", nw, 32'd1);
    access(1, 1'b1, 1'b1, BASE + 32'h40, 32'h13579BDF, 4'hF, rv, ev, eav, nw);
    check("both_waits",    nw,            32'd1);
    check("both_readdata", rv,            32'h0);
    check("both_err",      {31'b0, ev},   32'h1);
    check("both_pulse",    {31'b0, eav},  32'h0);
    access(1, 1'b1, 1'b0, BASE + 32'h40, 32'h0, 4'h0, rv, ev, eav, nw);
    check("both_mem_written", rv,          32'h13579BDF);
    check("both_after_err",   {31'b0, ev}, 32'h0);

`ifdef RAM_RANDOM_WAIT_EN
    // Randomised stalls: length bounded and data intact.
    for (int i = 0; i < 100; i++) begin
      access(0, 1'b1, 1'b0, BASE, 32'h0, 4'h0, rv, ev, eav, nw);
      check($sformatf("rand%0d_data", i),  rv,                      32'h24020010);
      check($sformatf("rand%0d_waits", i), {31'b0, wait_ok(nw, W)}, 32'h1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
